ddr_frame_arbiter: RTL and testbench
====================================

Name: ddr_frame_arbiter

Overview:
- Burst scheduler that shares the single DDR3 user-port burst engine between two requesters: the capture write path (128-bit words from the camera into a write FIFO) and the HDMI display read path (a read FIFO that feeds the display).
- Decides which side gets the next burst, generates the burst address, and manages triple frame buffering.
- With three banks the writer never overwrites the bank the display is reading, so output is tear-free.
- Sits between the two FIFOs' level counters and the burst datapath that moves the beats.

Parameters:
- ADDR_W, 28, width of burst_addr in 128-bit word units.
- BURST_LEN, 64, 128-bit beats per burst.
- FRAME_WORDS, 115200, words per frame (1280x720x16 bit / 128). Must be a multiple of BURST_LEN.
- STRIDE_LOG2, 17, log2 of bank stride in words. 2^STRIDE_LOG2 must be >= FRAME_WORDS.
- FIFO_W, 10, width of the FIFO level inputs.
- RD_FIFO_DEPTH, 512, depth of the read FIFO in words.

Ports:
- clk  in  1  DDR user clock
- rst_n  in  1  asynchronous active-low reset
- init_done  in  1  DDR calibration complete; level
- wr_fifo_usedw  in  FIFO_W  words waiting in the capture write FIFO
- wr_frame_sync  in  1  1-cycle pulse at the first word of a captured frame (clk domain)
- rd_fifo_usedw  in  FIFO_W  words held in the display read FIFO
- rd_frame_start  in  1  1-cycle pulse at display vsync (clk domain)
- burst_req  out  1  burst command valid
- burst_ack  in  1  burst engine accepts the command
- burst_rw  out  1  1 = write (FIFO->DDR), 0 = read
- burst_addr  out  ADDR_W  start word address of the burst
- burst_done  in  1  1-cycle pulse after the last beat of the accepted burst
- wr_bank  out  2  bank currently being written
- rd_bank  out  2  bank currently being displayed
- frame_valid  out  1  at least one complete frame is stored
- busy  out  1  a burst is requested or in flight

Behaviour:
Reset values:
- All outputs 0, except rd_bank = 2'd2 (wr_bank = 0).
- wr_offset = rd_offset = 0; last_done = 0; prio = write; rd_active = 0.
- An asserted rst_n mid-burst clears everything immediately; in-flight burst_done pulses are ignored after reset.

FSM: IDLE -> REQ -> WAIT -> IDLE.
- IDLE: move to REQ only if init_done = 1 and at least one side is eligible.
  - Register burst_rw and burst_addr, and assert burst_req on the next edge, giving 1-cycle latency from eligibility.
- REQ: hold burst_req, burst_rw and burst_addr stable until burst_ack = 1. Drop burst_req in the same edge that sees burst_ack, then go to WAIT.
- WAIT: on burst_done, update the offsets and return to IDLE. The next arbitration happens one cycle later.
- busy = (state != IDLE).

Eligibility:
- wr_elig = wr_fifo_usedw >= BURST_LEN.
- rd_elig = rd_active && frame_valid && rd_offset < FRAME_WORDS && rd_fifo_usedw <= RD_FIFO_DEPTH - BURST_LEN.
- Both eligible: grant the side opposite to the last grant. The first grant after reset goes to write.

Address:
- burst_addr = (bank << STRIDE_LOG2) + offset.
- Offsets advance by BURST_LEN on burst_done.

Write frame completion (wr_offset + BURST_LEN == FRAME_WORDS on a write burst_done):
- wr_offset <= 0; last_done <= wr_bank; frame_valid <= 1.
- wr_bank <= the single bank in {0,1,2} that is neither wr_bank nor the next-cycle rd_bank.

Display frame start (rd_frame_start):
- Set pending_rd. It is applied in IDLE only, never mid-burst: rd_offset <= 0, rd_active <= 1, rd_bank <= last_done.
- If frame completion and the pending_rd application land in the same cycle, the reader takes the old last_done value. The writer's next bank is computed from that new rd_bank.
- A rd_frame_start arriving before frame_valid is ignored for banking, but rd_active is still set.

Read frame end:
- After the last burst (rd_offset == FRAME_WORDS), reading stalls until the next rd_frame_start.

Capture resync (wr_frame_sync):
- Set pending_wr. Applied in IDLE: wr_offset <= 0, same bank, frame not marked complete.
- If it arrives while wr_offset == 0, it has no effect.

init_done deasserting:
- Finishes any current burst, then holds IDLE.

Test Plan:
- Hold wr_fifo_usedw = 64, rd_frame_start never pulsed, immediate burst_ack/burst_done -> writes only at addr 0, 64, 128, ...; after 1800 bursts frame_valid = 1, wr_bank = 1, last write of the frame at addr 115136.
- After the first frame, pulse rd_frame_start with rd_fifo_usedw = 0 and wr_fifo_usedw = 64 -> rd_bank = 0; grants alternate W, R, W, R; read addresses 0, 64, ...; write addresses 2^17 + n*64.
- Complete write frames continuously while rd_bank = 0 -> wr_bank sequence is 1, 2, 1, 2 and never 0; after rd_frame_start, rd_bank = last completed bank.
- Delay burst_ack 5 cycles -> burst_req stays high and burst_addr/burst_rw stay stable for all 5 cycles; burst_req drops the cycle after ack.
- Pulse wr_frame_sync mid-frame (wr_offset = 640) -> the next write address is bank base + 0; frame_valid is unchanged.
- Assert rst_n low in WAIT -> all outputs return to reset values asynchronously; a following burst_done causes no offset change.

Source files
------------

// File: rtl/ddr_frame_arbiter.sv
// Burst scheduler sharing one DDR3 user-port burst engine between the capture
// write path and the display read path, with triple frame buffering so the
// writer never touches the bank currently on screen.
module ddr_frame_arbiter #(
  parameter int ADDR_W        = 28,
  parameter int BURST_LEN     = 64,
  parameter int FRAME_WORDS   = 115200,
  parameter int STRIDE_LOG2   = 17,
  parameter int FIFO_W        = 10,
  parameter int RD_FIFO_DEPTH = 512
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              init_done,
  input  logic [FIFO_W-1:0] wr_fifo_usedw,
  input  logic              wr_frame_sync,
  input  logic [FIFO_W-1:0] rd_fifo_usedw,
  input  logic              rd_frame_start,
  output logic              burst_req,
  input  logic              burst_ack,
  output logic              burst_rw,
  output logic [ADDR_W-1:0] burst_addr,
  input  logic              burst_done,
  output logic [1:0]        wr_bank,
  output logic [1:0]        rd_bank,
  output logic              frame_valid,
  output logic              busy
);

  // One spare bit so a read offset can sit at FRAME_WORDS (frame fully read).
  localparam int OFF_W = STRIDE_LOG2 + 1;
  localparam logic [OFF_W-1:0]  BL_O     = OFF_W'(BURST_LEN);
  localparam logic [OFF_W-1:0]  FW_O     = OFF_W'(FRAME_WORDS);
  localparam logic [FIFO_W-1:0] BL_F     = FIFO_W'(BURST_LEN);
  localparam logic [FIFO_W-1:0] RD_LIMIT = FIFO_W'(RD_FIFO_DEPTH - BURST_LEN);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [OFF_W-1:0] wr_offset, rd_offset;
  logic [1:0]       last_done;
  logic             last_rw;      // 1 = previous grant was a write
  logic             rd_active;
  logic             pend_rd, pend_wr;

  logic             wr_elig, rd_elig;
  logic             grant, grant_wr, finish;
  logic             apply_rd, apply_wr;
  logic             wr_frame_end;
  logic [1:0]       rd_bank_nxt;

  // The one bank out of {0,1,2} used by neither the writer nor the reader.
  function automatic logic [1:0] free_bank(input logic [1:0] a, input logic [1:0] b);
    if (a != 2'd0 && b != 2'd0)      return 2'd0;
    else if (a != 2'd1 && b != 2'd1) return 2'd1;
    else                             return 2'd2;
  endfunction

  // Word address of a burst: bank base plus offset within the bank.
  function automatic logic [ADDR_W-1:0] bank_addr(input logic [1:0] bank,
                                                  input logic [OFF_W-1:0] off);
    return (ADDR_W'(bank) << STRIDE_LOG2) + ADDR_W'(off);
  endfunction

  assign busy = (state_q != IDLE);

  // Next-state, grant decision and frame-bookkeeping strobes.
  always_comb begin
    state_d      = state_q;
    grant        = 1'b0;
    finish       = 1'b0;
    wr_elig      = (wr_fifo_usedw >= BL_F);
    rd_elig      = rd_active && frame_valid && (rd_offset < FW_O) &&
                   (rd_fifo_usedw <= RD_LIMIT);
    // On a tie, hand the burst to the side that did not get the last one.
    grant_wr     = wr_elig && (!rd_elig || !last_rw);
    case (state_q)
      IDLE: begin
        // Pending frame events are applied first; arbitration waits a cycle.
        if (init_done && !pend_rd && !pend_wr && (wr_elig || rd_elig)) begin
          grant   = 1'b1;
          state_d = REQ;
        end
      end
      REQ:  if (burst_ack) state_d = WAIT;
      WAIT: begin
        if (burst_done) begin
          finish  = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    // Frame events only take effect between bursts, never mid-burst.
    apply_rd     = pend_rd && ((state_q == IDLE) || finish);
    apply_wr     = pend_wr && ((state_q == IDLE) || finish);
    wr_frame_end = finish && burst_rw && ((wr_offset + BL_O) == FW_O);
    // Reader takes the previously completed bank, only once a frame exists.
    rd_bank_nxt  = (apply_rd && frame_valid) ? last_done : rd_bank;
  end

  // State register, command registers, offsets and bank rotation.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      burst_req   <= 1'b0;
      burst_rw    <= 1'b0;
      burst_addr  <= '0;
      wr_bank     <= 2'd0;
      rd_bank     <= 2'd2;
      frame_valid <= 1'b0;
      wr_offset   <= '0;
      rd_offset   <= '0;
      last_done   <= 2'd0;
      last_rw     <= 1'b0;
      rd_active   <= 1'b0;
      pend_rd     <= 1'b0;
      pend_wr     <= 1'b0;
    end else begin
      state_q <= state_d;

      if (grant) begin
        burst_req  <= 1'b1;
        burst_rw   <= grant_wr;
        burst_addr <= grant_wr ? bank_addr(wr_bank, wr_offset)
                               : bank_addr(rd_bank, rd_offset);
        last_rw    <= grant_wr;
      end else if (state_q == REQ && burst_ack) begin
        burst_req  <= 1'b0;
      end

      if (rd_frame_start)     pend_rd <= 1'b1;
      else if (apply_rd)      pend_rd <= 1'b0;
      if (wr_frame_sync)      pend_wr <= 1'b1;
      else if (apply_wr)      pend_wr <= 1'b0;

      if (finish && burst_rw) begin
        if (wr_frame_end) begin
          wr_offset   <= '0;
          last_done   <= wr_bank;
          frame_valid <= 1'b1;
          wr_bank     <= free_bank(wr_bank, rd_bank_nxt);
        end else begin
          wr_offset   <= wr_offset + BL_O;
        end
      end
      // Capture resync restarts the current bank without completing it.
      if (apply_wr) wr_offset <= '0;

      if (finish && !burst_rw) rd_offset <= rd_offset + BL_O;
      if (apply_rd) begin
        rd_offset <= '0;
        rd_active <= 1'b1;
        rd_bank   <= rd_bank_nxt;
      end
    end
  end

endmodule

// File: tb/tb_ddr_frame_arbiter.sv
// Scoreboard bench for ddr_frame_arbiter: stimulus pushes the expected burst
// commands, a monitor pops them as the engine accepts each command.
module tb_ddr_frame_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        init_done;
  logic [9:0]  wr_fifo_usedw;
  logic        wr_frame_sync;
  logic [9:0]  rd_fifo_usedw;
  logic        rd_frame_start;
  logic        burst_req;
  logic        burst_ack;
  logic        burst_rw;
  logic [27:0] burst_addr;
  logic        burst_done;
  logic [1:0]  wr_bank;
  logic [1:0]  rd_bank;
  logic        frame_valid;
  logic        busy;

  logic        resp_done;
  logic        manual_done;
  int          ack_delay;
  logic        hold_done;

  logic [28:0] sb_q[$];
  string       name_q[$];
  logic [31:0] act_q[$];
  logic [31:0] exp_q[$];
  int          total;
  int          bad;

  assign burst_done = resp_done | manual_done;

  always #5 clk = ~clk;

  ddr_frame_arbiter dut (
    .clk(clk), .rst_n(rst_n), .init_done(init_done),
    .wr_fifo_usedw(wr_fifo_usedw), .wr_frame_sync(wr_frame_sync),
    .rd_fifo_usedw(rd_fifo_usedw), .rd_frame_start(rd_frame_start),
    .burst_req(burst_req), .burst_ack(burst_ack), .burst_rw(burst_rw),
    .burst_addr(burst_addr), .burst_done(burst_done),
    .wr_bank(wr_bank), .rd_bank(rd_bank), .frame_valid(frame_valid), .busy(busy)
  );

  // Burst engine model: ack after ack_delay cycles, then a done pulse.
  initial begin
    burst_ack = 1'b0;
    resp_done = 1'b0;
    forever begin
      @(posedge clk); #1;
      if (rst_n && burst_req && !burst_ack) begin
        for (int d = 0; d < ack_delay; d++) begin @(posedge clk); #1; end
        burst_ack = 1'b1;
        @(posedge clk); #1;
        burst_ack = 1'b0;
        if (!hold_done) begin
          resp_done = 1'b1;
          @(posedge clk); #1;
          resp_done = 1'b0;
        end
      end
    end
  end

  // Monitor: evaluates queued direct checks and accepted burst commands.
  initial begin
    total = 0;
    bad   = 0;
    forever begin
      @(negedge clk);
      while (name_q.size() > 0) begin
        string       nm;
        logic [31:0] a, e;
        nm = name_q.pop_front();
        a  = act_q.pop_front();
        e  = exp_q.pop_front();
        total++;
        if (a !== e) begin
          bad++;
          $display("FAIL %s: got %0d expected %0d", nm, a, e);
        end
      end
      if (rst_n && burst_req && burst_ack) begin
        total++;
        if (sb_q.size() == 0) begin
          bad++;
          $display("FAIL burst_unexpected: got rw=%0d addr=%0d expected none",
                   burst_rw, burst_addr);
        end else begin
          logic [28:0] e;
          e = sb_q.pop_front();
          if ({burst_rw, burst_addr} !== e) begin
            bad++;
            $display("FAIL burst_cmd: got rw=%0d addr=%0d expected rw=%0d addr=%0d",
                     burst_rw, burst_addr, e[28], e[27:0]);
          end
        end
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] a, input logic [31:0] e);
    name_q.push_back(nm);
    act_q.push_back(a);
    exp_q.push_back(e);
  endtask

  task automatic push_b(input logic rw, input int bank, input int off);
    sb_q.push_back({rw, 28'(bank * 131072 + off)});
  endtask

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin @(posedge clk); #1; end
  endtask

  // Wait until every expected burst was seen, then starve both sides.
  task automatic drain(input string nm);
    int n;
    n = 0;
    while (sb_q.size() != 0 && n < 8000) begin @(negedge clk); n++; end
    if (sb_q.size() != 0) begin
      chk({nm, "_timeout"}, 32'(sb_q.size()), 32'd0);
      sb_q.delete();
    end
    wr_fifo_usedw = 10'd0;
    rd_fifo_usedw = 10'd500;
    n = 0;
    while (busy && n < 100) begin @(negedge clk); n++; end
    if (busy) chk({nm, "_busy_timeout"}, 32'(busy), 32'd0);
    tick(2);
  endtask

  task automatic wait_req(input string nm);
    int n;
    n = 0;
    while (!burst_req && n < 50) begin @(posedge clk); #1; n++; end
    if (!burst_req) chk({nm, "_req_timeout"}, 32'(burst_req), 32'd1);
  endtask

  initial begin
    rst_n          = 1'b0;
    init_done      = 1'b0;
    wr_fifo_usedw  = 10'd0;
    wr_frame_sync  = 1'b0;
    rd_fifo_usedw  = 10'd500;
    rd_frame_start = 1'b0;
    manual_done    = 1'b0;
    ack_delay      = 0;
    hold_done      = 1'b0;
    tick(3);
    chk("rst_req",   32'(burst_req), 0);
    chk("rst_rw",    32'(burst_rw), 0);
    chk("rst_addr",  32'(burst_addr), 0);
    chk("rst_wbank", 32'(wr_bank), 0);
    chk("rst_rbank", 32'(rd_bank), 2);
    chk("rst_fvalid", 32'(frame_valid), 0);
    chk("rst_busy",  32'(busy), 0);
    rst_n = 1'b1;
    tick(2);

    // First frame: writes only, bank 0, offsets 0..115136.
    init_done = 1'b1;
    for (int n = 0; n < 1800; n++) push_b(1'b1, 0, n * 64);
    wr_fifo_usedw = 10'd64;
    drain("frame0");
    chk("f0_fvalid", 32'(frame_valid), 1);
    chk("f0_wbank",  32'(wr_bank), 1);
    chk("f0_rbank",  32'(rd_bank), 2);

    // Display starts during the first write: grants alternate W,R,W,R.
    push_b(1'b1, 1, 0);   push_b(1'b0, 0, 0);
    push_b(1'b1, 1, 64);  push_b(1'b0, 0, 64);
    push_b(1'b1, 1, 128); push_b(1'b0, 0, 128);
    wr_fifo_usedw = 10'd64;
    rd_fifo_usedw = 10'd0;
    wait_req("alt");
    rd_frame_start = 1'b1;
    tick(1);
    rd_frame_start = 1'b0;
    drain("alt");
    chk("alt_rbank", 32'(rd_bank), 0);

    // Continuous frames while bank 0 is on screen: writer rotates 1 -> 2 -> 1 -> 2.
    for (int n = 3; n < 1800; n++) push_b(1'b1, 1, n * 64);
    wr_fifo_usedw = 10'd64;
    drain("frame1");
    chk("f1_wbank", 32'(wr_bank), 2);
    chk("f1_rbank", 32'(rd_bank), 0);
    for (int n = 0; n < 1800; n++) push_b(1'b1, 2, n * 64);
    wr_fifo_usedw = 10'd64;
    drain("frame2");
    chk("f2_wbank", 32'(wr_bank), 1);
    for (int n = 0; n < 1800; n++) push_b(1'b1, 1, n * 64);
    wr_fifo_usedw = 10'd64;
    drain("frame3");
    chk("f3_wbank", 32'(wr_bank), 2);

    // New vsync: reader moves to the last completed bank (1), restarts at 0.
    rd_frame_start = 1'b1;
    tick(1);
    rd_frame_start = 1'b0;
    tick(3);
    chk("vs_rbank", 32'(rd_bank), 1);
    push_b(1'b0, 1, 0);
    rd_fifo_usedw = 10'd0;
    drain("vs_read");
    chk("vs_wbank", 32'(wr_bank), 2);

    // Ack held off for 5 cycles: command must stay stable.
    ack_delay = 5;
    push_b(1'b1, 2, 0);
    wr_fifo_usedw = 10'd64;
    wait_req("dly");
    wr_fifo_usedw = 10'd0;
    for (int c = 0; c < 5; c++) begin
      chk("dly_req",  32'(burst_req), 1);
      chk("dly_rw",   32'(burst_rw), 1);
      chk("dly_addr", 32'(burst_addr), 32'd262144);
      if (c < 4) tick(1);
    end
    tick(2);
    chk("dly_req_drop", 32'(burst_req), 0);
    drain("dly");
    ack_delay = 0;

    // Advance to offset 640, then resync capture: restart at bank base.
    for (int n = 1; n < 10; n++) push_b(1'b1, 2, n * 64);
    wr_fifo_usedw = 10'd64;
    drain("pre_sync");
    wr_frame_sync = 1'b1;
    tick(1);
    wr_frame_sync = 1'b0;
    tick(3);
    push_b(1'b1, 2, 0);
    wr_fifo_usedw = 10'd64;
    drain("sync");
    chk("sync_fvalid", 32'(frame_valid), 1);
    chk("sync_wbank",  32'(wr_bank), 2);

    // Reset while waiting for burst_done, then a stray done pulse.
    hold_done = 1'b1;
    push_b(1'b1, 2, 64);
    wr_fifo_usedw = 10'd64;
    wait_req("wrst");
    wr_fifo_usedw = 10'd0;
    tick(3);
    chk("wrst_busy_wait", 32'(busy), 1);
    rst_n = 1'b0;
    #1;
    chk("wrst_req",    32'(burst_req), 0);
    chk("wrst_busy",   32'(busy), 0);
    chk("wrst_addr",   32'(burst_addr), 0);
    chk("wrst_wbank",  32'(wr_bank), 0);
    chk("wrst_rbank",  32'(rd_bank), 2);
    chk("wrst_fvalid", 32'(frame_valid), 0);
    tick(2);
    rst_n     = 1'b1;
    hold_done = 1'b0;
    tick(1);
    manual_done = 1'b1;
    tick(1);
    manual_done = 1'b0;
    tick(2);
    push_b(1'b1, 0, 0);
    wr_fifo_usedw = 10'd64;
    drain("post_rst");

    chk("sb_leftover", 32'(sb_q.size()), 0);
    @(negedge clk);
    @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
